// File: rtl/s5378_n484_bist.sv
// s5378_n484_bist
// Pattern-generation and signature-compaction BIST engine for the s5378
// n484 logic cone.
//
// A 22-bit LFSR produces the stimulus applied to the cone inputs. The
// cone's single-bit response is compacted each cycle into a 16-bit MISR,
// and the final signature is compared against the expected value that
// was captured when the run started.
//
// Ports
//   CK       in   1   clock, rising edge active
//   reset    in   1   asynchronous active-high reset
//   start    in   1   run request, sampled only in IDLE
//   abort    in   1   terminate the current run, back to IDLE
//   seed     in  22   LFSR start pattern (zero is replaced by 1)
//   n_pat    in  16   number of patterns to apply
//   exp_sig  in  16   expected signature
//   resp     in   1   combinational cone response to the current pat
//   pat      out 22   stimulus, pat[0] = n1850gat ... pat[21] = n2506gat
//   busy     out  1   high while patterns are being applied
//   done     out  1   one-cycle completion pulse
//   pass     out  1   final signature matched exp_sig
//   sig      out 16   final signature
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; pat, sig and pass hold their values
// RUN   | one pattern applied and one response compacted per cycle
// DONE  | result published; done high for this single cycle

module s5378_n484_bist #(
    parameter logic [15:0] MISR_POLY = 16'h1021,
    parameter logic [15:0] MISR_INIT = 16'hFFFF
) (
    input  logic        CK,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [21:0] seed,
    input  logic [15:0] n_pat,
    input  logic [15:0] exp_sig,
    input  logic        resp,
    output logic [21:0] pat,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] misr;
    logic [15:0] cnt;
    logic [15:0] n_pat_q;
    logic [15:0] exp_sig_q;

    logic [15:0] misr_next;
    logic [21:0] pat_next;
    logic        last_cycle;

    // resp belongs to the pattern currently on pat, so it is folded in on
    // the same edge that replaces that pattern.
    always_comb begin
        misr_next  = {misr[14:0], 1'b0} ^ ((misr[15] ^ resp) ? MISR_POLY : 16'h0000);
        pat_next   = {pat[20:0], pat[21] ^ pat[20]};
        last_cycle = (cnt == (n_pat_q - 16'd1));
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pat       <= 22'h000000;
            misr      <= MISR_INIT;
            cnt       <= 16'h0000;
            n_pat_q   <= 16'h0000;
            exp_sig_q <= 16'h0000;
            sig       <= 16'h0000;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort outranks a simultaneous start
                    if (start && !abort) begin
                        misr      <= MISR_INIT;
                        cnt       <= 16'h0000;
                        n_pat_q   <= n_pat;
                        exp_sig_q <= exp_sig;
                        if (n_pat == 16'h0000) begin
                            // empty run: publish the untouched MISR, pat unchanged
                            state <= DONE;
                            sig   <= MISR_INIT;
                            pass  <= (MISR_INIT == exp_sig);
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            pat   <= (seed == 22'h000000) ? 22'h000001 : seed;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // run discarded; pat, sig and pass keep their values
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        misr <= misr_next;
                        pat  <= pat_next;
                        cnt  <= cnt + 16'd1;
                        if (last_cycle) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sig   <= misr_next;
                            pass  <= (misr_next == exp_sig_q);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s5378_n484_bist.sv
// tb_s5378_n484_bist
// Self-checking bench for s5378_n484_bist. A stand-in cone drives resp
// from pat; a sequence-level model produces the expected patterns,
// signature and pass flag for directed and random runs.

module tb_s5378_n484_bist;

    localparam logic [15:0] POLY      = 16'h1021;
    localparam logic [15:0] INIT      = 16'hFFFF;
    localparam logic [21:0] CONE_MASK = 22'h2A5C3;

    logic        CK = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [21:0] seed;
    logic [15:0] n_pat;
    logic [15:0] exp_sig;
    logic        resp;
    logic [21:0] pat;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;

    int checks   = 0;
    int failures = 0;
    int cone_mode = 0;

    logic [21:0] last_pat;
    logic [15:0] last_sig;
    logic        last_pass;

    s5378_n484_bist #(
        .MISR_POLY(POLY),
        .MISR_INIT(INIT)
    ) dut (
        .CK     (CK),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .seed   (seed),
        .n_pat  (n_pat),
        .exp_sig(exp_sig),
        .resp   (resp),
        .pat    (pat),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .sig    (sig)
    );

    always #5 CK = ~CK;

    // mode 0: constant 0, mode 1: constant 1, otherwise a small nonlinear cone
    function automatic logic cone(input logic [21:0] p, input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (^(p & CONE_MASK)) ^ (p[3] & p[17]);
    endfunction

    always_comb resp = cone(pat, cone_mode);

    function automatic logic [21:0] lfsr_step(input logic [21:0] p);
        int unsigned v;
        int unsigned fb;
        v  = int'(p);
        fb = ((v >> 21) ^ (v >> 20)) & 1;
        return 22'(((v << 1) & 32'h3FFFFF) | fb);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic r);
        int unsigned v;
        int unsigned top;
        v   = int'(m);
        top = ((v >> 15) & 1) ^ int'(r);
        v   = (v << 1) & 32'hFFFF;
        if (top != 0) v = v ^ int'(POLY);
        return 16'(v);
    endfunction

    function automatic logic [15:0] model_sig(input logic [21:0] s, input int n, input int mode);
        logic [21:0] p;
        logic [15:0] m;
        p = (s == 22'h0) ? 22'h1 : s;
        m = INIT;
        for (int i = 0; i < n; i++) begin
            m = misr_step(m, cone(p, mode));
            p = lfsr_step(p);
        end
        return m;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    // One complete run. abort_at < 0 means no abort; poke_start toggles
    // start during RUN to show it is ignored.
    task automatic run_test(input logic [21:0] s, input logic [15:0] n, input logic [15:0] e,
                            input int mode, input int abort_at, input bit poke_start);
        logic [21:0] p;
        logic [15:0] m;
        int          n_i;
        n_i       = int'(n);
        cone_mode = mode;
        seed      = s;
        n_pat     = n;
        exp_sig   = e;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        seed    = 22'($urandom);
        n_pat   = 16'($urandom);
        exp_sig = 16'($urandom);
        if (n_i == 0) begin
            check_val("zero_busy", 32'(busy), 32'd0);
            check_val("zero_done", 32'(done), 32'd1);
            check_val("zero_sig", 32'(sig), 32'(INIT));
            check_val("zero_pass", 32'(pass), 32'(INIT == e));
            check_val("zero_pat", 32'(pat), 32'(last_pat));
            last_sig  = INIT;
            last_pass = (INIT == e);
            tick();
            check_val("zero_done_clr", 32'(done), 32'd0);
            return;
        end
        p = (s == 22'h0) ? 22'h1 : s;
        m = INIT;
        for (int i = 0; i < n_i; i++) begin
            if (i < 3 || i == n_i - 1) begin
                check_val("run_pat", 32'(pat), 32'(p));
                check_val("run_busy", 32'(busy), 32'd1);
                check_val("run_done", 32'(done), 32'd0);
            end
            if (poke_start) start = (i < n_i - 1);
            if (i == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                check_val("abort_busy", 32'(busy), 32'd0);
                check_val("abort_done", 32'(done), 32'd0);
                check_val("abort_sig", 32'(sig), 32'(last_sig));
                check_val("abort_pass", 32'(pass), 32'(last_pass));
                check_val("abort_pat", 32'(pat), 32'(p));
                last_pat = p;
                tick();
                check_val("abort_no_done", 32'(done), 32'd0);
                check_val("abort_pat_hold", 32'(pat), 32'(p));
                return;
            end
            m = misr_step(m, cone(p, mode));
            p = lfsr_step(p);
            tick();
        end
        start = 1'b0;
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("done_busy", 32'(busy), 32'd0);
        check_val("done_sig", 32'(sig), 32'(m));
        check_val("done_pass", 32'(pass), 32'(m == e));
        check_val("done_pat", 32'(pat), 32'(p));
        last_sig  = m;
        last_pass = (m == e);
        last_pat  = p;
        tick();
        check_val("done_clr", 32'(done), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_pat", 32'(pat), 32'(p));
    endtask

    initial begin
        logic [15:0] golden;
        logic [21:0] rs;
        logic [15:0] rn;
        int          rmode;
        int          rab;

        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        seed    = 22'h0;
        n_pat   = 16'h0;
        exp_sig = 16'h0;
        #12;
        check_val("rst_pat", 32'(pat), 32'd0);
        check_val("rst_sig", 32'(sig), 32'd0);
        check_val("rst_pass", 32'(pass), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        reset     = 1'b0;
        last_pat  = 22'h0;
        last_sig  = 16'h0;
        last_pass = 1'b0;
        tick();

        // single pattern from seed 1
        run_test(22'h000001, 16'd1, 16'hEFDF, 0, -1, 1'b0);
        check_val("one_pat_sig", 32'(sig), 32'h0000EFDF);
        check_val("one_pat_pass", 32'(pass), 32'd1);

        // zero seed substitutes 1
        run_test(22'h000000, 16'd2, 16'h0000, 0, -1, 1'b0);

        // empty run
        run_test(22'h12345, 16'd0, 16'hFFFF, 0, -1, 1'b0);
        check_val("empty_pass", 32'(pass), 32'd1);

        // abort mid-run, after a known result is in place
        run_test(22'h0ABCD, 16'd100, 16'h1234, 2, 50, 1'b1);

        // abort and start together in IDLE
        seed  = 22'h3;
        n_pat = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_val("idle_abort_busy", 32'(busy), 32'd0);
        check_val("idle_abort_done", 32'(done), 32'd0);
        check_val("idle_abort_pat", 32'(pat), 32'(last_pat));
        tick();
        check_val("idle_abort_busy2", 32'(busy), 32'd0);

        // asynchronous reset between edges in the middle of a run
        cone_mode = 2;
        seed      = 22'h5;
        n_pat     = 16'd100;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_pat", 32'(pat), 32'd0);
        check_val("mid_rst_sig", 32'(sig), 32'd0);
        check_val("mid_rst_pass", 32'(pass), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        #2;
        reset     = 1'b0;
        last_pat  = 22'h0;
        last_sig  = 16'h0;
        last_pass = 1'b0;
        tick();
        check_val("post_rst_done", 32'(done), 32'd0);
        run_test(22'h000001, 16'd1, 16'h0000, 0, -1, 1'b0);
        check_val("post_rst_sig", 32'(sig), 32'h0000EFDF);

        // long run with golden signature, then with resp stuck at 1
        golden = model_sig(22'h1F2E3D, 1000, 2);
        run_test(22'h1F2E3D, 16'd1000, golden, 2, -1, 1'b0);
        check_val("golden_pass", 32'(pass), 32'd1);
        run_test(22'h1F2E3D, 16'd1000, golden, 1, -1, 1'b0);
        check_val("stuck_pass", 32'(pass), 32'(model_sig(22'h1F2E3D, 1000, 1) == golden));

        // random runs
        for (int k = 0; k < 12; k++) begin
            rs    = 22'($urandom);
            if (k == 0) rs = 22'h0;
            rn    = 16'($urandom_range(0, 40));
            rmode = int'($urandom_range(0, 2));
            rab   = ($urandom_range(0, 3) == 0 && rn > 1) ? int'($urandom_range(0, int'(rn) - 1)) : -1;
            if ($urandom_range(0, 1) == 1)
                run_test(rs, rn, model_sig(rs, int'(rn), rmode), rmode, rab, 1'($urandom_range(0, 1)));
            else
                run_test(rs, rn, 16'($urandom), rmode, rab, 1'($urandom_range(0, 1)));
        end

        // full-length run, counter must not wrap
        run_test(22'h2AAAAA, 16'hFFFF, 16'h0000, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s5378_n484_bist.md
S5378_N484_BIST -- requirements
Module: s5378_n484_bist

Interface
REQ-001 Parameter MISR_POLY, default 16'h1021, is the MISR feedback polynomial (x^16+x^12+x^5+1).
REQ-002 Parameter MISR_INIT, default 16'hFFFF, is the MISR start value.
REQ-003 CK  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 abort  in  1  terminate the current run and return to IDLE.
REQ-007 seed  in  22  LFSR start pattern, captured on an accepted start.
REQ-008 n_pat  in  16  number of patterns to apply, captured on an accepted start.
REQ-009 exp_sig  in  16  expected signature, captured on an accepted start.
REQ-010 resp  in  1  combinational n484 response of the cone under test.
REQ-011 pat  out  22  stimulus; pat[0]..pat[21] drive the s5378 n484 cone inputs in port order, n1850gat first and n2506gat last.
REQ-012 busy  out  1  high in RUN.
REQ-013 done  out  1  one-cycle pulse in DONE.
REQ-014 pass  out  1  signature-match flag, valid from done until the next accepted start.
REQ-015 sig  out  16  final MISR signature, held until the next accepted start.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE->RUN on start when n_pat!=0.
- IDLE->DONE on start when n_pat==0.
- RUN->DONE after n_pat compaction cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-017 Accepted start SHALL load:
- pat <= seed, or 22'h000001 if seed==0;
- misr <= MISR_INIT;
- cnt <= 0.
REQ-018 Each RUN cycle SHALL compact resp into the MISR:
- fb = misr[15]^resp;
- misr <= {misr[14:0],1'b0} ^ (fb ? MISR_POLY : 0).
REQ-019 Each RUN cycle SHALL also:
- advance the LFSR: pat <= {pat[20:0], pat[21]^pat[20]};
- increment cnt.
REQ-020 Response timing: resp is sampled at the same edge that replaces the pattern producing it; no extra pipeline stage.
REQ-021 Run length:
- on the RUN edge where cnt==n_pat-1, the final compaction occurs and the state goes to DONE;
- exactly n_pat responses are compacted, covering patterns step 0 (seed) through step n_pat-1.
REQ-022 On entering DONE:
- sig SHALL take the final misr;
- pass SHALL equal (final misr == captured exp_sig);
- done SHALL be 1 for exactly one cycle.
REQ-023 n_pat==0 SHALL give sig=MISR_INIT, done one cycle after start, and no change to pat.
REQ-024 start SHALL be ignored in RUN and DONE; changes to seed, n_pat or exp_sig after capture SHALL have no effect.
REQ-025 abort in RUN SHALL:
- move to IDLE at the next edge with no done pulse;
- leave sig and pass unchanged;
- hold pat at its current value.
REQ-026 abort SHALL take priority over run completion in the same cycle, and over start in IDLE.
REQ-027 pat SHALL hold its last value in DONE and IDLE.
REQ-028 cnt SHALL be 16 bits and SHALL never wrap; n_pat=16'hFFFF gives 65535 patterns.

Reset
REQ-029 reset SHALL asynchronously force: state=IDLE, pat=0, misr=MISR_INIT, cnt=0, sig=0, pass=0, busy=0, done=0.
REQ-030 reset asserted mid-RUN SHALL discard the run with no done pulse; after reset release, the first start SHALL behave as from power-up.

Verification
REQ-031 seed=22'h000001, n_pat=1, resp=0, exp_sig=16'hEFDF -> pat=22'h000001 for one RUN cycle, then sig=16'hEFDF, pass=1, done pulse one cycle later.
REQ-032 seed=0, n_pat=2, resp=0 -> pat sequence 22'h000001 then 22'h000002; done after 2 RUN cycles.
REQ-033 n_pat=0, exp_sig=16'hFFFF -> busy stays 0, sig=16'hFFFF, pass=1, done the cycle after start.
REQ-034 n_pat=100, abort asserted at RUN cycle 50 -> IDLE next edge, no done, sig and pass keep their previous values.
REQ-035 reset pulsed mid-RUN between edges -> outputs at reset values immediately; a new start with n_pat=1, seed=1, resp=0 gives sig=16'hEFDF.
REQ-036 Against the real cone with n_pat=1000 and the golden signature -> pass=1; the same run with resp forced to 1 -> pass=0.
